// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V constants and fetch FSM state type
package riscv_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [1:0] {
    RESET_WAIT,
    FETCH,
    FLUSH
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small shift-style synchronous FIFO with registered head
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : write request and data (dropped when full)
//   pop             : remove head (ignored when empty)
//   flush           : clear all entries; wins over push and pop
//   count           : current occupancy
//   head            : oldest entry, or EMPTY_VAL when empty
module fetch_fifo #(
  parameter int             W         = 32,
  parameter int             DEPTH     = 2,
  parameter logic [W-1:0]   EMPTY_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [W-1:0]                 head
);

  localparam int CW = $clog2(DEPTH + 1);

  // Entry 0 is always the head, so the head output comes straight from a
  // register. Unused slots are held at EMPTY_VAL so an empty FIFO presents
  // EMPTY_VAL on its head without any output mux.
  logic [W-1:0]  r_mem      [DEPTH];
  logic [W-1:0]  w_mem_next [DEPTH];
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_after_pop;
  logic          w_do_pop;
  logic          w_do_push;

  always_comb begin
    w_do_pop    = pop && (r_count != '0);
    w_after_pop = r_count - CW'(w_do_pop);
    w_do_push   = push && (w_after_pop != CW'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      w_mem_next[i] = r_mem[i];
    end
    if (w_do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        w_mem_next[i] = r_mem[i+1];
      end
      w_mem_next[DEPTH-1] = EMPTY_VAL;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (w_do_push && (w_after_pop == CW'(i))) begin
        w_mem_next[i] = push_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= EMPTY_VAL;
      end
    end else begin
      r_count <= w_after_pop + CW'(w_do_push);
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= w_mem_next[i];
      end
    end
  end

  assign count = r_count;
  assign head  = r_mem[0];

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with credit-limited imem requests
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   imem_req_valid/addr/ready        : fetch request handshake
//   imem_rsp_valid/data              : in-order instruction returns
//   redirect_valid/pc                : taken branch/jump from execute
//   stall, PCen                      : downstream backpressure, issue enable
//   inst_valid, inst, inst_pc        : instruction presented to decode
//   opcode, funct3, funct7           : fields sliced from inst
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  input  logic        PCen,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7
);

  fetch_state_t r_state;
  logic [31:0]  r_fetch_pc;

  logic [1:0]   w_outstanding;
  logic [1:0]   w_q_count;
  logic [31:0]  w_tag_head;
  logic [63:0]  w_out_head;
  logic         w_redirect;
  logic         w_rsp_hit;
  logic         w_pop_out;
  logic         w_accept;
  logic [2:0]   w_credit_sum;
  logic [1:0]   w_out_post;
  logic [31:0]  w_redirect_pc;

  assign w_redirect    = redirect_valid && (r_state != RESET_WAIT);
  // A response with nothing outstanding is stray and must not touch state.
  assign w_rsp_hit     = imem_rsp_valid && (w_outstanding != 2'd0);
  assign w_pop_out     = (w_q_count != 2'd0) && !stall;
  assign w_redirect_pc = redirect_pc & ~32'h3;

  // The slot freed by this cycle's output pop counts as credit; otherwise a
  // 1-cycle memory settles at one outstanding plus one queued and issue would
  // stall every other cycle. This never withdraws a pending request: a pop
  // permanently lowers the sum, and responses only move credit between
  // outstanding and the queue.
  assign w_credit_sum  = {1'b0, w_outstanding} + {1'b0, w_q_count} - {2'b00, w_pop_out};

  assign imem_req_valid = (r_state == FETCH) && PCen && !redirect_valid
                          && (w_credit_sum < 3'd2);
  assign w_accept       = imem_req_valid && imem_req_ready;
  assign imem_req_addr  = r_fetch_pc;

  // Outstanding count after this edge; a redirect cycle never issues.
  assign w_out_post = w_outstanding - {1'b0, w_rsp_hit};

  fetch_fifo #(
    .W         (32),
    .DEPTH     (2),
    .EMPTY_VAL (32'h0)
  ) u_tag_q (
    .clk       (clk),
    .rst       (rst),
    .push      (w_accept),
    .push_data (r_fetch_pc),
    .pop       (imem_rsp_valid),
    .flush     (1'b0),
    .count     (w_outstanding),
    .head      (w_tag_head)
  );

  fetch_fifo #(
    .W         (64),
    .DEPTH     (2),
    .EMPTY_VAL ({NOP_INST, 32'h0})
  ) u_out_q (
    .clk       (clk),
    .rst       (rst),
    .push      ((r_state == FETCH) && w_rsp_hit),
    .push_data ({imem_rsp_data, w_tag_head}),
    .pop       (w_pop_out),
    .flush     (w_redirect),
    .count     (w_q_count),
    .head      (w_out_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RESET_WAIT;
      r_fetch_pc <= RESET_PC;
    end else begin
      case (r_state)
        RESET_WAIT: r_state <= FETCH;
        FETCH: begin
          if (redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
            r_state    <= (w_out_post != 2'd0) ? FLUSH : FETCH;
          end else if (w_accept) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
          end
        end
        FLUSH: begin
          if (redirect_valid) begin
            r_fetch_pc <= w_redirect_pc;
          end else if (w_out_post == 2'd0) begin
            r_state <= FETCH;
          end
        end
        default: r_state <= RESET_WAIT;
      endcase
    end
  end

  assign inst_valid = (w_q_count != 2'd0);
  assign inst       = w_out_head[63:32];
  assign inst_pc    = w_out_head[31:0];
  assign opcode     = inst[6:0];
  assign funct3     = inst[14:12];
  assign funct7     = inst[31:25];

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        PCen;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .PCen           (PCen),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7)
  );

  int          checks = 0;
  int          errors = 0;
  // Memory model: addresses accepted but not yet answered, oldest first.
  logic [31:0] pending[$];
  // Oldest pending entries that belong to a fetch path abandoned by a redirect.
  int          stale;
  logic [31:0] exp_fetch;
  logic [31:0] exp_deliver;
  bit          prev_wait;
  logic [31:0] prev_addr;
  bit          last_req_valid;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle. Entered and left 1 time unit after a rising edge.
  task automatic cycle(input bit st, input bit pcen, input bit rdy, input bit rsp_en,
                       input bit redir, input logic [31:0] rpc, input bit spur);
    logic        v;
    logic [31:0] word;
    logic [31:0] acc_addr;
    bit          popped;
    bit          acc;
    v = inst_valid;
    if (stale > 0) check("flush_no_inst", 32'(inst_valid), 32'd0);
    if (v) begin
      word = exp_deliver + 32'h100;
      check("inst_pc", inst_pc, exp_deliver);
      check("inst", inst, word);
      check("opcode", 32'(opcode), 32'(word[6:0]));
      check("funct3", 32'(funct3), 32'(word[14:12]));
      check("funct7", 32'(funct7), 32'(word[31:25]));
    end else begin
      check("idle_inst", inst, 32'h0000_0013);
      check("idle_pc", inst_pc, 32'd0);
    end
    stall          = st;
    PCen           = pcen;
    imem_req_ready = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    popped         = rsp_en && (pending.size() > 0);
    imem_rsp_valid = popped || (spur && (pending.size() == 0));
    imem_rsp_data  = popped ? pending[0] + 32'h100 : 32'hDEAD_BEEF;
    #1;
    last_req_valid = imem_req_valid;
    if (redir || stale > 0 || !pcen) check("no_issue", 32'(imem_req_valid), 32'd0);
    if (prev_wait && !redir) begin
      if (pcen) check("no_withdraw", 32'(imem_req_valid), 32'd1);
      if (imem_req_valid) check("addr_hold", imem_req_addr, prev_addr);
    end
    acc      = imem_req_valid && rdy;
    acc_addr = imem_req_addr;
    if (acc) check("req_addr", imem_req_addr, exp_fetch);
    prev_wait = imem_req_valid && !rdy && !redir;
    prev_addr = imem_req_addr;
    @(posedge clk);
    #1;
    if (popped) begin
      pending.delete(0);
      if (stale > 0) stale--;
    end
    if (acc) begin
      pending.push_back(acc_addr);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (redir) begin
      exp_fetch   = rpc & ~32'h3;
      exp_deliver = rpc & ~32'h3;
      stale       = pending.size();
      check("redir_clears", 32'(inst_valid), 32'd0);
    end else if (v && !st) begin
      exp_deliver = exp_deliver + 32'd4;
    end
    check("credit", 32'(pending.size() <= 2), 32'd1);
  endtask

  task automatic do_reset(input bit stale_rsp);
    rst            = 1'b1;
    stall          = 1'b0;
    PCen           = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    @(posedge clk);
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst", inst, 32'h0000_0013);
    check("rst_inst_pc", inst_pc, 32'd0);
    check("rst_opcode", 32'(opcode), 32'h13);
    check("rst_funct3", 32'(funct3), 32'd0);
    check("rst_funct7", 32'(funct7), 32'd0);
    rst = 1'b0;
    pending.delete();
    stale       = 0;
    exp_fetch   = RESET_PC;
    exp_deliver = RESET_PC;
    prev_wait   = 1'b0;
    // A late response from before reset lands while nothing is outstanding.
    imem_rsp_valid = stale_rsp;
    imem_rsp_data  = 32'h1234_5678;
    #1;
    check("rw_no_issue", 32'(imem_req_valid), 32'd0);
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    check("rst_rsp_ignored", 32'(inst_valid), 32'd0);
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, RESET_PC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    do_reset(1'b0);

    // Steady flow with a 1-cycle memory: one instruction per cycle.
    repeat (2) cycle(0, 1, 1, 1, 0, 32'h0, 0);
    for (int i = 0; i < 6; i++) begin
      check("thru_valid", 32'(inst_valid), 32'd1);
      cycle(0, 1, 1, 1, 0, 32'h0, 0);
    end

    // Downstream stall: queue fills and issue stops.
    repeat (5) cycle(1, 1, 1, 1, 0, 32'h0, 0);
    check("stall_req_low", 32'(imem_req_valid), 32'd0);
    check("stall_inst_held", 32'(inst_valid), 32'd1);
    repeat (4) cycle(0, 1, 1, 1, 0, 32'h0, 0);

    // Build up two outstanding requests, then redirect to 0x40.
    repeat (3) cycle(0, 1, 1, 0, 0, 32'h0, 0);
    check("two_outstanding", pending.size(), 32'd2);
    cycle(0, 1, 1, 0, 1, 32'h40, 0);
    n = 0;
    while (!inst_valid && n < 20) begin
      cycle(0, 1, 1, 1, 0, 32'h0, 0);
      n++;
    end
    check("redir_first_valid", 32'(inst_valid), 32'd1);
    check("redir_target", inst_pc, 32'h40);
    repeat (3) cycle(0, 1, 1, 1, 0, 32'h0, 0);

    // PCen low: no issue, in-flight work still delivered.
    repeat (3) cycle(0, 0, 1, 1, 0, 32'h0, 0);
    repeat (4) cycle(0, 1, 1, 1, 0, 32'h0, 0);

    // Drain completely, then a stray response with nothing outstanding.
    n = 0;
    while ((pending.size() != 0 || inst_valid) && n < 10) begin
      cycle(0, 0, 1, 1, 0, 32'h0, 0);
      n++;
    end
    check("drained", 32'(pending.size() == 0 && !inst_valid), 32'd1);
    cycle(0, 0, 1, 0, 0, 32'h0, 1);
    check("stray_rsp_ignored", 32'(inst_valid), 32'd0);

    // Memory not ready for 4 cycles: address held, PC advances on accept only.
    repeat (4) cycle(0, 1, 0, 1, 0, 32'h0, 0);
    check("stray_no_underflow", 32'(last_req_valid), 32'd1);
    check("ready_hold_addr", imem_req_addr, exp_fetch);
    repeat (6) cycle(0, 1, 1, 1, 0, 32'h0, 0);

    // Reset in mid-stream with responses still in flight.
    check("mid_inflight", 32'(pending.size() > 0), 32'd1);
    do_reset(1'b1);
    repeat (4) cycle(0, 1, 1, 1, 0, 32'h0, 0);

    // Randomized traffic against the stream model.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) == 0,
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 29) == 0,
            {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))},
            0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 3-stage pipeline: owns the fetch PC and issues requests to instruction memory. It buffers returned instruction words with their PCs in a 2-entry queue and presents one instruction per cycle, with opcode/funct3/funct7 pre-split, to the decode controller directly downstream. It honours downstream stall and `PCen`, and handles branch/jump redirects by flushing queued and in-flight fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  32  word-aligned fetch address.
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_rsp_valid`  in  1  instruction word returned; in-order, ≥1 cycle after acceptance.
- `imem_rsp_data`  in  32  returned instruction word.
- `redirect_valid`  in  1  taken branch/JAL/JALR from execute.
- `redirect_pc`  in  32  new fetch target; bits [1:0] forced to 0.
- `stall`  in  1  downstream cannot take an instruction this cycle.
- `PCen`  in  1  from controller; 0 freezes new request issue.
- `inst_valid`  out  1  `inst`/`inst_pc` hold a real instruction.
- `inst`  out  32  instruction, or NOP 32'h0000_0013 when `inst_valid`=0.
- `inst_pc`  out  32  PC of `inst`; 0 when invalid.
- `opcode`  out  7  `inst[6:0]`.
- `funct3`  out  3  `inst[14:12]`.
- `funct7`  out  7  `inst[31:25]`.

## Operation
- FSM states: RESET_WAIT, FETCH, FLUSH.
- RESET_WAIT: entered on reset; lasts 1 cycle, then goes to FETCH.
- Credit rule: `outstanding + q_count ≤ 2` at all times.
  - `outstanding` is accepted requests without a response, 0..2.
  - `q_count` is queue occupancy, 0..2.
- Issue: `imem_req_valid` = FETCH && `PCen` && !`redirect_valid` && credit available (sum < 2).
  - On acceptance (valid && ready): `fetch_pc += 4`, `outstanding++`, and the issued PC is pushed to a 2-entry tag queue.
  - Address stays stable while valid && !ready, unless a redirect occurs.
  - A request may be withdrawn only by a redirect.
- Response in FETCH: pops the oldest tag and pushes {data, tag PC} into the output queue; `outstanding--`.
- Response with `outstanding`=0: ignored; no counter underflow.
- Output: head of the queue drives `inst`/`inst_pc`, and `inst_valid` = `q_count` ≠ 0. Pop when `inst_valid` && !`stall`.
- Simultaneous response push and output pop: both occur and `q_count` is unchanged. Overflow is impossible by the credit rule.
- Redirect (highest priority, any state except RESET_WAIT):
  - `fetch_pc` ← `redirect_pc`; output queue cleared.
  - No request issued that cycle.
  - Next state is FLUSH if the post-cycle `outstanding` > 0, else FETCH.
- FLUSH:
  - Responses are discarded (tag popped, `outstanding--`, nothing queued).
  - No issue.
  - Go to FETCH in the cycle after `outstanding` reaches 0.
  - A redirect in FLUSH updates `fetch_pc` and stays in FLUSH.
- `PCen`=0 blocks new issue only. In-flight responses are still queued, and the output queue still drains.

## Timing
- Reset values:
  - `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`.
  - `inst_valid`=0, `inst`=32'h0000_0013, `inst_pc`=0, `opcode`=7'b0010011, `funct3`=0, `funct7`=0.
  - `outstanding`=0, `q_count`=0, state RESET_WAIT.
- First `imem_req_valid` goes high in the 2nd cycle after the cycle in which `rst` is sampled low.
- Response-to-output latency: 1 cycle. A response on edge N makes `inst_valid` high after edge N, unless the queue was non-empty.
- Throughput: 1 instruction/cycle for a memory with 1-cycle response latency and `ready`=1.
- Redirect sampled on edge N: outputs show `inst_valid`=0 after edge N. The first request to `redirect_pc` is issued no earlier than cycle N+1.
- `rst` mid-operation: everything returns to reset values on that edge, and in-flight responses arriving afterwards are ignored (`outstanding`=0).
- All outputs are registered except `imem_req_valid`, which is decoded from registered state and `PCen`/`redirect_valid`. `imem_req_addr` is registered. The field outputs are slices of registered `inst`.

## Structure
- Shared package `riscv_pkg` holds:
  - `NOP_INST` = 32'h0000_0013.
  - Opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI.
  - `fetch_state_t` enum {RESET_WAIT, FETCH, FLUSH}.
- One sub-module, `fetch_fifo`: parameterised depth-2 synchronous FIFO with push, pop, flush, count, and head outputs. It is instantiated twice: the 32-bit tag queue and the 64-bit {data, pc} output queue.

## Test plan
- Reset, `ready`=1, 1-cycle memory returning addr+0x100: first request at 0x0 in the 2nd post-reset cycle, then `inst_pc` sequence 0x0, 0x4, 0x8 on consecutive cycles with `inst` = pc+0x100, and `opcode`/`funct3`/`funct7` matching the slices.
- `stall` high for 5 cycles in steady flow: queue fills to 2, `imem_req_valid` drops, and nothing is lost or duplicated after release.
- Redirect to 0x40 with 2 requests outstanding: both late responses are discarded, `inst_valid`=0 during FLUSH, and the next valid `inst_pc` is 0x40.
- `PCen`=0 for 3 cycles: no new requests, in-flight instructions still delivered, and issue resumes at the next PC.
- Bench drives `imem_rsp_valid` with `outstanding`=0: no output and no counter change. Separately, `rst` mid-stream: all outputs return to reset values, including `inst`=0x13.
- `ready` low for 4 cycles: `imem_req_addr` is held stable, and the PC advances only on acceptance.
